// File: rtl/datapath_router.sv
// Registered mode-select steering between the program/variable RAM read ports and decode/execute.
// Instruction and peek words are latched; load words are queued in a small FIFO for execute.
module datapath_router #(
    parameter int WORD_SIZE        = 16,
    parameter int MODE_SELECT_SIZE = 3,
    parameter int LOAD_DEPTH       = 4,
    parameter int CNT_W            = $clog2(LOAD_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WORD_SIZE-1:0]        p_ram_data,
    input  logic [WORD_SIZE-1:0]        v_ram_data,
    input  logic [MODE_SELECT_SIZE-1:0] mode,
    input  logic                        mode_valid,
    output logic                        mode_ready,
    output logic [WORD_SIZE-1:0]        instruction,
    output logic                        instr_valid,
    output logic [WORD_SIZE-1:0]        peek,
    output logic                        peek_valid,
    output logic [WORD_SIZE-1:0]        load,
    output logic                        load_valid,
    input  logic                        load_ready,
    output logic [CNT_W-1:0]            load_count,
    output logic                        load_flag
);

    localparam int PTR_W = $clog2(LOAD_DEPTH);

    localparam logic [MODE_SELECT_SIZE-1:0] MODE_PEEK   = MODE_SELECT_SIZE'(1);
    localparam logic [MODE_SELECT_SIZE-1:0] MODE_PUSH_P = MODE_SELECT_SIZE'(2);
    localparam logic [MODE_SELECT_SIZE-1:0] MODE_PUSH_V = MODE_SELECT_SIZE'(3);
    localparam logic [MODE_SELECT_SIZE-1:0] MODE_FSET   = MODE_SELECT_SIZE'(4);
    localparam logic [MODE_SELECT_SIZE-1:0] MODE_FCLR   = MODE_SELECT_SIZE'(5);
    localparam logic [MODE_SELECT_SIZE-1:0] MODE_FLUSH  = MODE_SELECT_SIZE'(6);

    logic [WORD_SIZE-1:0] instr_reg, instr_next;
    logic [WORD_SIZE-1:0] peek_reg, peek_next;
    logic                 instr_valid_reg, instr_valid_next;
    logic                 peek_valid_reg, peek_valid_next;
    logic                 load_flag_reg, load_flag_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;

    logic [WORD_SIZE-1:0] fifo_mem [LOAD_DEPTH];
    logic [LOAD_DEPTH-1:0] wr_en;

    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic [WORD_SIZE-1:0] push_data;

    // Handshake flags come from the registered count only, so neither ready nor
    // valid depends combinationally on the other side's request.
    assign mode_ready = (count_reg != CNT_W'(LOAD_DEPTH));
    assign load_valid = (count_reg != '0);
    assign accept     = mode_valid && mode_ready;
    assign pop        = load_valid && load_ready;

    // Command decode; modes 0, 7 and anything above 7 all fetch an instruction.
    always_comb begin
        instr_next       = instr_reg;
        peek_next        = peek_reg;
        load_flag_next   = load_flag_reg;
        instr_valid_next = 1'b0;
        peek_valid_next  = 1'b0;
        push             = 1'b0;
        push_data        = p_ram_data;
        flush            = 1'b0;
        if (accept) begin
            case (mode)
                MODE_PEEK: begin
                    peek_next       = p_ram_data;
                    peek_valid_next = 1'b1;
                end
                MODE_PUSH_P: push = 1'b1;
                MODE_PUSH_V: begin
                    push      = 1'b1;
                    push_data = v_ram_data;
                end
                MODE_FSET:  load_flag_next = 1'b1;
                MODE_FCLR:  load_flag_next = 1'b0;
                MODE_FLUSH: flush          = 1'b1;
                default: begin
                    instr_next       = p_ram_data;
                    instr_valid_next = 1'b1;
                end
            endcase
        end
    end

    // Occupancy and pointers; a flush overrides a same-cycle pop.
    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (flush) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg       <= '0;
            peek_reg        <= '0;
            instr_valid_reg <= 1'b0;
            peek_valid_reg  <= 1'b0;
            load_flag_reg   <= 1'b0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            instr_reg       <= instr_next;
            peek_reg        <= peek_next;
            instr_valid_reg <= instr_valid_next;
            peek_valid_reg  <= peek_valid_next;
            load_flag_reg   <= load_flag_next;
            count_reg       <= count_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LOAD_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Storage is not reset: entries are only observed after being written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LOAD_DEPTH; i++) begin
            if (wr_en[i]) fifo_mem[i] <= push_data;
        end
    end

    assign instruction = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign peek        = peek_reg;
    assign peek_valid  = peek_valid_reg;
    assign load        = fifo_mem[rd_ptr_reg];
    assign load_count  = count_reg;
    assign load_flag   = load_flag_reg;

endmodule

// File: tb/tb_datapath_router.sv
// Directed bench for datapath_router: a table of per-cycle vectors plus hand-written
// sequences for asynchronous reset and the first accept after reset release.
module tb_datapath_router;

    logic        clk;
    logic        rst_n;
    logic [15:0] p_ram_data;
    logic [15:0] v_ram_data;
    logic [2:0]  mode;
    logic        mode_valid;
    logic        mode_ready;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] peek;
    logic        peek_valid;
    logic [15:0] load;
    logic        load_valid;
    logic        load_ready;
    logic [2:0]  load_count;
    logic        load_flag;

    int tests_run;
    int tests_failed;

    datapath_router #(
        .WORD_SIZE(16),
        .MODE_SELECT_SIZE(3),
        .LOAD_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .p_ram_data(p_ram_data),
        .v_ram_data(v_ram_data),
        .mode(mode),
        .mode_valid(mode_valid),
        .mode_ready(mode_ready),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .peek(peek),
        .peek_valid(peek_valid),
        .load(load),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_count(load_count),
        .load_flag(load_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic [2:0]  md;
        logic [15:0] p;
        logic [15:0] v;
        logic        lr;
        logic [15:0] e_instr;
        logic        e_iv;
        logic [15:0] e_peek;
        logic        e_pv;
        logic        e_lv;
        logic [15:0] e_load;
        logic [2:0]  e_cnt;
        logic        e_flag;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic mv, input logic [2:0] md, input logic [15:0] p,
                                input logic [15:0] v, input logic lr,
                                input logic [15:0] e_instr, input logic e_iv,
                                input logic [15:0] e_peek, input logic e_pv,
                                input logic e_lv, input logic [15:0] e_load,
                                input logic [2:0] e_cnt, input logic e_flag, input logic e_rdy);
        vec_t r;
        r.mv = mv; r.md = md; r.p = p; r.v = v; r.lr = lr;
        r.e_instr = e_instr; r.e_iv = e_iv; r.e_peek = e_peek; r.e_pv = e_pv;
        r.e_lv = e_lv; r.e_load = e_load; r.e_cnt = e_cnt; r.e_flag = e_flag; r.e_rdy = e_rdy;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input int idx, input logic [15:0] e_instr, input logic e_iv,
                                 input logic [15:0] e_peek, input logic e_pv, input logic e_lv,
                                 input logic [15:0] e_load, input logic [2:0] e_cnt,
                                 input logic e_flag, input logic e_rdy);
        chk("instruction", idx, 32'(instruction), 32'(e_instr));
        chk("instr_valid", idx, 32'(instr_valid), 32'(e_iv));
        chk("peek",        idx, 32'(peek),        32'(e_peek));
        chk("peek_valid",  idx, 32'(peek_valid),  32'(e_pv));
        chk("load_valid",  idx, 32'(load_valid),  32'(e_lv));
        if (e_lv) chk("load", idx, 32'(load), 32'(e_load));
        chk("load_count",  idx, 32'(load_count),  32'(e_cnt));
        chk("load_flag",   idx, 32'(load_flag),   32'(e_flag));
        chk("mode_ready",  idx, 32'(mode_ready),  32'(e_rdy));
    endtask

    task automatic drive(input logic mv, input logic [2:0] md, input logic [15:0] p,
                         input logic [15:0] v, input logic lr);
        mode_valid = mv;
        mode       = md;
        p_ram_data = p;
        v_ram_data = v;
        load_ready = lr;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);

        //        mv  md    p         v         lr   instr     iv  peek      pv  lv  load      cnt  flg rdy
        vecs.push_back(mk(1, 3'd0, 16'h1234, 16'h0000, 0, 16'h1234, 1, 16'h0000, 0, 0, 16'h0000, 3'd0, 0, 1));
        vecs.push_back(mk(0, 3'd0, 16'hFFFF, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 0, 16'h0000, 3'd0, 0, 1));
        vecs.push_back(mk(1, 3'd2, 16'hA000, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 1, 16'hA000, 3'd1, 0, 1));
        vecs.push_back(mk(1, 3'd2, 16'hA001, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 1, 16'hA000, 3'd2, 0, 1));
        vecs.push_back(mk(1, 3'd2, 16'hA002, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 1, 16'hA000, 3'd3, 0, 1));
        vecs.push_back(mk(1, 3'd2, 16'hA003, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 1, 16'hA000, 3'd4, 0, 0));
        // full: a mode 0 stalls too, then mode 3 is held across the first pop
        vecs.push_back(mk(1, 3'd0, 16'h9999, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 1, 16'hA000, 3'd4, 0, 0));
        vecs.push_back(mk(1, 3'd3, 16'h0000, 16'h3333, 0, 16'h1234, 0, 16'h0000, 0, 1, 16'hA000, 3'd4, 0, 0));
        vecs.push_back(mk(1, 3'd3, 16'h0000, 16'h3333, 1, 16'h1234, 0, 16'h0000, 0, 1, 16'hA001, 3'd3, 0, 1));
        vecs.push_back(mk(1, 3'd3, 16'h0000, 16'h3333, 1, 16'h1234, 0, 16'h0000, 0, 1, 16'hA002, 3'd3, 0, 1));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 16'h0000, 0, 1, 16'hA003, 3'd2, 0, 1));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 16'h0000, 0, 1, 16'h3333, 3'd1, 0, 1));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 16'h0000, 0, 0, 16'h0000, 3'd0, 0, 1));
        // count 2, then simultaneous push and pop across the pointer wrap
        vecs.push_back(mk(1, 3'd2, 16'hB001, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 1, 16'hB001, 3'd1, 0, 1));
        vecs.push_back(mk(1, 3'd2, 16'hB002, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 1, 16'hB001, 3'd2, 0, 1));
        vecs.push_back(mk(1, 3'd3, 16'h0000, 16'h00FF, 1, 16'h1234, 0, 16'h0000, 0, 1, 16'hB002, 3'd2, 0, 1));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 16'h0000, 0, 1, 16'h00FF, 3'd1, 0, 1));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 16'h0000, 0, 0, 16'h0000, 3'd0, 0, 1));
        // flag set, peek in between, flag clear, then mode 7 fetches
        vecs.push_back(mk(1, 3'd4, 16'h0000, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0, 0, 16'h0000, 3'd0, 1, 1));
        vecs.push_back(mk(1, 3'd1, 16'h5555, 16'h0000, 0, 16'h1234, 0, 16'h5555, 1, 0, 16'h0000, 3'd0, 1, 1));
        vecs.push_back(mk(1, 3'd5, 16'h0000, 16'h0000, 0, 16'h1234, 0, 16'h5555, 0, 0, 16'h0000, 3'd0, 0, 1));
        vecs.push_back(mk(1, 3'd7, 16'h7777, 16'h0000, 0, 16'h7777, 1, 16'h5555, 0, 0, 16'h0000, 3'd0, 0, 1));
        // count 3, flush with a same-cycle pop, then a fresh push reaches the head
        vecs.push_back(mk(1, 3'd2, 16'hC001, 16'h0000, 0, 16'h7777, 0, 16'h5555, 0, 1, 16'hC001, 3'd1, 0, 1));
        vecs.push_back(mk(1, 3'd2, 16'hC002, 16'h0000, 0, 16'h7777, 0, 16'h5555, 0, 1, 16'hC001, 3'd2, 0, 1));
        vecs.push_back(mk(1, 3'd3, 16'h0000, 16'hC003, 0, 16'h7777, 0, 16'h5555, 0, 1, 16'hC001, 3'd3, 0, 1));
        vecs.push_back(mk(1, 3'd6, 16'h0000, 16'h0000, 1, 16'h7777, 0, 16'h5555, 0, 0, 16'h0000, 3'd0, 0, 1));
        vecs.push_back(mk(1, 3'd2, 16'hBEEF, 16'h0000, 0, 16'h7777, 0, 16'h5555, 0, 1, 16'hBEEF, 3'd1, 0, 1));
        vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 1, 16'h7777, 0, 16'h5555, 0, 0, 16'h0000, 3'd0, 0, 1));
        // pop on an empty FIFO is ignored
        vecs.push_back(mk(0, 3'd0, 16'h0000, 16'h0000, 1, 16'h7777, 0, 16'h5555, 0, 0, 16'h0000, 3'd0, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        check_outputs(-1, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
        $display("[TB] reset state checked");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].mv, vecs[i].md, vecs[i].p, vecs[i].v, vecs[i].lr);
            step();
            $display("[TB] vec %0d: mv=%0b mode=%0d p=%h v=%h lr=%0b -> instr=%h iv=%0b peek=%h pv=%0b lv=%0b load=%h cnt=%0d flag=%0b rdy=%0b",
                     i, vecs[i].mv, vecs[i].md, vecs[i].p, vecs[i].v, vecs[i].lr,
                     instruction, instr_valid, peek, peek_valid, load_valid, load, load_count, load_flag, mode_ready);
            check_outputs(i, vecs[i].e_instr, vecs[i].e_iv, vecs[i].e_peek, vecs[i].e_pv,
                          vecs[i].e_lv, vecs[i].e_load, vecs[i].e_cnt, vecs[i].e_flag, vecs[i].e_rdy);
        end

        // Mid-stream asynchronous reset with count 3 and load_flag set.
        drive(1'b1, 3'd2, 16'hD001, 16'h0, 1'b0); step();
        drive(1'b1, 3'd2, 16'hD002, 16'h0, 1'b0); step();
        drive(1'b1, 3'd2, 16'hD003, 16'h0, 1'b0); step();
        drive(1'b1, 3'd4, 16'h0,    16'h0, 1'b0); step();
        check_outputs(100, 16'h7777, 1'b0, 16'h5555, 1'b0, 1'b1, 16'hD001, 3'd3, 1'b1, 1'b1);
        $display("[TB] pre-reset: cnt=%0d flag=%0b load=%h", load_count, load_flag, load);
        drive(1'b1, 3'd0, 16'hEEEE, 16'h0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_outputs(101, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
        $display("[TB] async reset: instr=%h peek=%h cnt=%0d flag=%0b rdy=%0b",
                 instruction, peek, load_count, load_flag, mode_ready);

        // Held command is discarded while reset is asserted; first edge after release accepts.
        step();
        check_outputs(102, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        drive(1'b1, 3'd0, 16'hABCD, 16'h0, 1'b0);
        step();
        check_outputs(103, 16'hABCD, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
        $display("[TB] first accept after reset: instr=%h iv=%0b", instruction, instr_valid);
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        step();
        check_outputs(104, 16'hABCD, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
